sccb_multi_cam_seq: RTL

Parametrised SCCB configuration sequencer for up to N_CAM OV7670-class cameras. Each camera has its own SCCB lines and the cameras share one SCCB master. The block runs the power-up sequence, generating the camera clock and holding the cameras in reset, then settles. It then reads an external register table and writes every entry to each camera in turn. Table entries can also encode timed delays and an end marker. It sits between the camera pins and the capture logic and replaces the single-camera control top.

---
 rtl/sccb_multi_cam_seq_pkg.sv | 40 ++++
 rtl/sccb_multi_cam_seq_master.sv | 122 ++++++++++++
 rtl/sccb_multi_cam_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_multi_cam_seq_pkg.sv
// Shared types and constants for the multi-camera SCCB configuration sequencer.
package sccb_multi_cam_seq_pkg;

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [7:0]  DLY_PREFIX = 8'hFF;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } sccb_entry_t;

  typedef enum logic [3:0] {
    S_PWR_RST,
    S_SETTLE,
    S_STEP_HOLD,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT_LO,
    S_WAIT_HI,
    S_DELAY,
    S_NEXT_CAM,
    S_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    M_IDLE,
    M_START,
    M_BIT,
    M_STOP
  } mst_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sccb_multi_cam_seq_master.sv
// SCCB 3-phase write master: start, {id,W}, addr, data (each + don't-care bit), stop.
module sccb_master
  import sccb_multi_cam_seq_pkg::*;
#(
  parameter int unsigned QTR = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_tx,
  input  logic [6:0] dev_id,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       ready,
  output logic       sclk,
  output logic       sdat_on,
  output logic       sdat_out
);

  localparam int unsigned QW = (QTR > 1) ? $clog2(QTR) : 1;

  mst_state_e      st_q, st_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      ph_q, ph_d;
  logic [3:0]      bpos_q, bpos_d;
  logic [1:0]      byte_q, byte_d;
  logic [23:0]     sh_q, sh_d;
  logic            tick;
  logic            ack;

  assign tick = (qcnt_q == QW'(QTR - 1));
  assign ack  = (bpos_q == 4'd8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= M_IDLE;
      qcnt_q <= '0;
      ph_q   <= '0;
      bpos_q <= '0;
      byte_q <= '0;
      sh_q   <= '0;
    end else begin
      st_q   <= st_d;
      qcnt_q <= qcnt_d;
      ph_q   <= ph_d;
      bpos_q <= bpos_d;
      byte_q <= byte_d;
      sh_q   <= sh_d;
    end
  end

  // Each bit is four quarter periods: data changes while sclk is low in quarter 0.
  always_comb begin
    st_d     = st_q;
    qcnt_d   = tick ? '0 : qcnt_q + QW'(1);
    ph_d     = ph_q;
    bpos_d   = bpos_q;
    byte_d   = byte_q;
    sh_d     = sh_q;
    ready    = 1'b0;
    sclk     = 1'b1;
    sdat_on  = 1'b0;
    sdat_out = 1'b1;
    unique case (st_q)
      M_IDLE: begin
        ready  = 1'b1;
        qcnt_d = '0;
        if (start_tx) begin
          sh_d = {dev_id, 1'b0, reg_addr, reg_data};
          ph_d = 2'd0;
          st_d = M_START;
        end
      end
      M_START: begin
        sdat_on  = 1'b1;
        sdat_out = (ph_q == 2'd0);
        if (tick) begin
          if (ph_q == 2'd1) begin
            st_d   = M_BIT;
            ph_d   = 2'd0;
            bpos_d = '0;
            byte_d = '0;
          end else begin
            ph_d = ph_q + 2'd1;
          end
        end
      end
      M_BIT: begin
        sclk     = ph_q[1];
        sdat_on  = ~ack;
        sdat_out = ack | sh_q[23];
        if (tick) begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd3) begin
            if (ack) begin
              bpos_d = '0;
              if (byte_q == 2'd2) begin
                st_d = M_STOP;
                ph_d = 2'd0;
              end else begin
                byte_d = byte_q + 2'd1;
              end
            end else begin
              bpos_d = bpos_q + 4'd1;
              sh_d   = {sh_q[22:0], 1'b0};
            end
          end
        end
      end
      M_STOP: begin
        sdat_on  = 1'b1;
        sclk     = (ph_q != 2'd0);
        sdat_out = (ph_q == 2'd2);
        if (tick) begin
          if (ph_q == 2'd2) st_d = M_IDLE;
          else              ph_d = ph_q + 2'd1;
        end
      end
      default: st_d = M_IDLE;
    endcase
  end

endmodule

// File: rtl/sccb_multi_cam_seq.sv
// Power-up and register-table sequencer driving N_CAM cameras through one shared SCCB master.
module sccb_multi_cam_seq
  import sccb_multi_cam_seq_pkg::*;
#(
  parameter int unsigned N_CAM      = 2,
  parameter int unsigned N_REGS     = 64,
  parameter int unsigned AW         = $clog2(N_REGS),
  parameter logic [6:0]  CAM_ID     = 7'h21,
  parameter int unsigned RST_CYC    = 100000,
  parameter int unsigned SETTLE_CYC = 100000,
  parameter int unsigned DLY_UNIT   = 100000,
  parameter int unsigned XCLK_DIV   = 2,
  parameter int unsigned SCCB_QTR   = 125
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  output logic [AW-1:0]    tbl_addr,
  input  logic [15:0]      tbl_data,
  output logic [N_CAM-1:0] sclk,
  output logic [N_CAM-1:0] sdat_on,
  output logic [N_CAM-1:0] sdat_out,
  output logic [N_CAM-1:0] cam_rst_n,
  output logic [N_CAM-1:0] cam_pwdn,
  output logic             xclk,
  output logic [2:0]       cur_cam,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_MAX = max3(RST_CYC, SETTLE_CYC, 255 * DLY_UNIT);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned XW      = (XCLK_DIV > 1) ? $clog2(XCLK_DIV) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t RST_LOAD    = cnt_t'(RST_CYC - 1);
  localparam cnt_t SETTLE_LOAD = cnt_t'(SETTLE_CYC - 1);

  seq_state_e  state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [2:0]  cur_q, cur_d;
  logic        pend_q, pend_d;
  sccb_entry_t entry_q, entry_d;
  logic [XW-1:0] xdiv_q;
  logic        xclk_q;

  logic        start_tx;
  logic        advance;
  logic        restart;
  logic        mst_rst;
  logic        m_ready, m_sclk, m_sdat_on, m_sdat_out;
  seq_state_e  hold_or_fetch;

  assign mst_rst       = ~rst_n;
  assign hold_or_fetch = step_mode ? S_STEP_HOLD : S_FETCH;

  sccb_master #(.QTR(SCCB_QTR)) u_master (
    .clk     (clk),
    .rst     (mst_rst),
    .start_tx(start_tx),
    .dev_id  (CAM_ID),
    .reg_addr(entry_q.addr),
    .reg_data(entry_q.data),
    .ready   (m_ready),
    .sclk    (m_sclk),
    .sdat_on (m_sdat_on),
    .sdat_out(m_sdat_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PWR_RST;
      cnt_q   <= RST_LOAD;
      idx_q   <= '0;
      cur_q   <= '0;
      pend_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      entry_q <= entry_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xdiv_q <= '0;
      xclk_q <= 1'b0;
    end else if (xdiv_q == XW'(XCLK_DIV - 1)) begin
      xdiv_q <= '0;
      xclk_q <= ~xclk_q;
    end else begin
      xdiv_q <= xdiv_q + XW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    entry_d  = entry_q;
    start_tx = 1'b0;
    advance  = 1'b0;
    restart  = 1'b0;
    unique case (state_q)
      S_PWR_RST: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = hold_or_fetch;
        else             cnt_d   = cnt_q - cnt_t'(1);
      end
      S_STEP_HOLD: if (step || !step_mode) state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE: begin
        entry_d = sccb_entry_t'(tbl_data);
        if (tbl_data == END_MARK) begin
          state_d = S_NEXT_CAM;
        end else if (tbl_data[15:8] == DLY_PREFIX) begin
          if (tbl_data[7:0] == 8'd0) begin
            advance = 1'b1;
          end else begin
            cnt_d   = cnt_t'(tbl_data[7:0]) * cnt_t'(DLY_UNIT) - cnt_t'(1);
            state_d = S_DELAY;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (m_ready) begin
          start_tx = 1'b1;
          state_d  = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (start)    pend_d  = 1'b1;
        if (!m_ready) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (start) pend_d = 1'b1;
        if (m_ready) begin
          if (pend_q || start) restart = 1'b1;
          else                 advance = 1'b1;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d   = cnt_q - cnt_t'(1);
      end
      S_NEXT_CAM: begin
        idx_d = '0;
        if (cur_q < 3'(N_CAM - 1)) begin
          cur_d   = cur_q + 3'd1;
          state_d = hold_or_fetch;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  ;
      default: state_d = S_PWR_RST;
    endcase

    // The last table slot finishes the camera instead of wrapping the index.
    if (advance) begin
      if (idx_q == AW'(N_REGS - 1)) begin
        state_d = S_NEXT_CAM;
      end else begin
        idx_d   = idx_q + AW'(1);
        state_d = hold_or_fetch;
      end
    end

    if (start && state_q != S_WAIT_LO && state_q != S_WAIT_HI) restart = 1'b1;

    if (restart) begin
      state_d  = S_PWR_RST;
      cnt_d    = RST_LOAD;
      idx_d    = '0;
      cur_d    = '0;
      pend_d   = 1'b0;
      start_tx = 1'b0;
    end
  end

  always_comb begin
    sclk     = '1;
    sdat_on  = '0;
    sdat_out = '1;
    for (int unsigned i = 0; i < N_CAM; i++) begin
      if (cur_q == 3'(i)) begin
        sclk[i]     = m_sclk;
        sdat_on[i]  = m_sdat_on;
        sdat_out[i] = m_sdat_out;
      end
    end
  end

  assign tbl_addr  = idx_q;
  assign cur_cam   = cur_q;
  assign xclk      = xclk_q;
  assign busy      = (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign cam_rst_n = {N_CAM{state_q != S_PWR_RST}};
  assign cam_pwdn  = '0;

endmodule
